// File: rtl/mips_pipe_defs_pkg.sv
// Shared MIPS pipeline definitions: datapath widths, ALUOp classes, control bundle, zero register.
package mips_pipe_defs;

  localparam int DATA_W = 32;
  localparam int REG_AW = 5;

  localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_RTYPE = 2'b10,
    ALUOP_IMM   = 2'b11
  } alu_op_e;

  typedef struct packed {
    logic       reg_dst;
    logic       alu_src;
    logic       mem_read;
    logic       mem_write;
    logic       memto_reg;
    logic       reg_write;
    logic [1:0] alu_op;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = 8'h00;

  // Destination register chosen by EX: rd for R-type, rt otherwise.
  function automatic logic [REG_AW-1:0] write_reg(input logic reg_dst,
                                                  input logic [REG_AW-1:0] rd,
                                                  input logic [REG_AW-1:0] rt);
    return reg_dst ? rd : rt;
  endfunction

endpackage

// File: rtl/id_ex_stage_reg_if.sv
// ID-side inputs and EX-side outputs of the ID/EX register; master drives ID, slave is the stage.
interface id_ex_if
  import mips_pipe_defs::*;
#(
  parameter int DW = DATA_W,
  parameter int AW = REG_AW
);
  logic [AW-1:0] ID_rs, ID_rt, ID_rd;
  logic          ID_UsesRt;
  logic [DW-1:0] ID_ReadData1, ID_ReadData2, ID_Imm;
  logic          ID_RegDst, ID_ALUSrc, ID_MemRead, ID_MemWrite, ID_MemtoReg, ID_RegWrite;
  logic [1:0]    ID_ALUOp;
  logic          Flush;

  logic [AW-1:0] EX_rs, EX_rt, EX_rd;
  logic [DW-1:0] EX_ReadData1, EX_ReadData2, EX_Imm;
  logic          EX_RegDst, EX_ALUSrc, EX_MemRead, EX_MemWrite, EX_MemtoReg, EX_RegWrite;
  logic [1:0]    EX_ALUOp;
  logic [AW-1:0] EX_WriteRegister;
  logic          Stall;

  modport master (
    output ID_rs, ID_rt, ID_rd, ID_UsesRt, ID_ReadData1, ID_ReadData2, ID_Imm,
           ID_RegDst, ID_ALUSrc, ID_MemRead, ID_MemWrite, ID_MemtoReg, ID_RegWrite,
           ID_ALUOp, Flush,
    input  EX_rs, EX_rt, EX_rd, EX_ReadData1, EX_ReadData2, EX_Imm,
           EX_RegDst, EX_ALUSrc, EX_MemRead, EX_MemWrite, EX_MemtoReg, EX_RegWrite,
           EX_ALUOp, EX_WriteRegister, Stall
  );

  modport slave (
    input  ID_rs, ID_rt, ID_rd, ID_UsesRt, ID_ReadData1, ID_ReadData2, ID_Imm,
           ID_RegDst, ID_ALUSrc, ID_MemRead, ID_MemWrite, ID_MemtoReg, ID_RegWrite,
           ID_ALUOp, Flush,
    output EX_rs, EX_rt, EX_rd, EX_ReadData1, EX_ReadData2, EX_Imm,
           EX_RegDst, EX_ALUSrc, EX_MemRead, EX_MemWrite, EX_MemtoReg, EX_RegWrite,
           EX_ALUOp, EX_WriteRegister, Stall
  );
endinterface

// File: rtl/id_ex_stage_reg_load_use_detect.sv
// Combinational load-use hazard detection: a load in EX whose rt is consumed by the ID instruction.
module load_use_detect
  import mips_pipe_defs::*;
(
  input  logic              ex_mem_read_i,
  input  logic [REG_AW-1:0] ex_rt_i,
  input  logic [REG_AW-1:0] id_rs_i,
  input  logic [REG_AW-1:0] id_rt_i,
  input  logic              id_uses_rt_i,
  input  logic              flush_i,
  output logic              hz_o,
  output logic              stall_o
);

  // A flushed ID instruction is discarded, so it never needs to wait.
  always_comb begin
    hz_o    = ex_mem_read_i & (ex_rt_i != REG_ZERO) &
              ((ex_rt_i == id_rs_i) | (id_uses_rt_i & (ex_rt_i == id_rt_i)));
    stall_o = hz_o & ~flush_i;
  end

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use stall and bubble insertion.
// Optional HAZARD_STATS_EN adds saturating StallCount/FlushCount outputs.
module id_ex_stage_reg
  import mips_pipe_defs::*;
#(
  parameter int DW = DATA_W,
  parameter int AW = REG_AW
)(
  input  logic        clk,
  input  logic        reset,
`ifdef HAZARD_STATS_EN
  output logic [15:0] StallCount,
  output logic [15:0] FlushCount,
`endif
  id_ex_if.slave      bus
);

  logic [AW-1:0] rs_q, rt_q, rd_q, rs_d, rt_d, rd_d;
  logic [DW-1:0] rd1_q, rd2_q, imm_q, rd1_d, rd2_d, imm_d;
  ctrl_t         ctrl_q, ctrl_d;
  logic          hz_s, stall_nf_s, stall_s;

  load_use_detect u_lud (
    .ex_mem_read_i (ctrl_q.mem_read),
    .ex_rt_i       (rt_q),
    .id_rs_i       (bus.ID_rs),
    .id_rt_i       (bus.ID_rt),
    .id_uses_rt_i  (bus.ID_UsesRt),
    .flush_i       (bus.Flush),
    .hz_o          (hz_s),
    .stall_o       (stall_nf_s)
  );

  assign stall_s = stall_nf_s & ~reset;

  // Flush or hazard both yield an all-zero bubble; otherwise take the ID fields.
  always_comb begin
    rs_d   = bus.ID_rs;
    rt_d   = bus.ID_rt;
    rd_d   = bus.ID_rd;
    rd1_d  = bus.ID_ReadData1;
    rd2_d  = bus.ID_ReadData2;
    imm_d  = bus.ID_Imm;
    ctrl_d = '{reg_dst:   bus.ID_RegDst,   alu_src:   bus.ID_ALUSrc,
               mem_read:  bus.ID_MemRead,  mem_write: bus.ID_MemWrite,
               memto_reg: bus.ID_MemtoReg, reg_write: bus.ID_RegWrite,
               alu_op:    bus.ID_ALUOp};
    if (bus.Flush || hz_s) begin
      rs_d   = '0;
      rt_d   = '0;
      rd_d   = '0;
      rd1_d  = '0;
      rd2_d  = '0;
      imm_d  = '0;
      ctrl_d = CTRL_NOP;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rs_q   <= '0;
      rt_q   <= '0;
      rd_q   <= '0;
      rd1_q  <= '0;
      rd2_q  <= '0;
      imm_q  <= '0;
      ctrl_q <= CTRL_NOP;
    end else begin
      rs_q   <= rs_d;
      rt_q   <= rt_d;
      rd_q   <= rd_d;
      rd1_q  <= rd1_d;
      rd2_q  <= rd2_d;
      imm_q  <= imm_d;
      ctrl_q <= ctrl_d;
    end
  end

  assign bus.EX_rs            = rs_q;
  assign bus.EX_rt            = rt_q;
  assign bus.EX_rd            = rd_q;
  assign bus.EX_ReadData1     = rd1_q;
  assign bus.EX_ReadData2     = rd2_q;
  assign bus.EX_Imm           = imm_q;
  assign bus.EX_RegDst        = ctrl_q.reg_dst;
  assign bus.EX_ALUSrc        = ctrl_q.alu_src;
  assign bus.EX_MemRead       = ctrl_q.mem_read;
  assign bus.EX_MemWrite      = ctrl_q.mem_write;
  assign bus.EX_MemtoReg      = ctrl_q.memto_reg;
  assign bus.EX_RegWrite      = ctrl_q.reg_write;
  assign bus.EX_ALUOp         = ctrl_q.alu_op;
  assign bus.EX_WriteRegister = write_reg(ctrl_q.reg_dst, rd_q, rt_q);
  assign bus.Stall            = stall_s;

`ifdef HAZARD_STATS_EN
  logic [15:0] stall_cnt_q, flush_cnt_q;

  // Saturating event counters; reset has priority over counting.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= 16'd0;
      flush_cnt_q <= 16'd0;
    end else begin
      if (stall_s && (stall_cnt_q != 16'hFFFF)) stall_cnt_q <= stall_cnt_q + 16'd1;
      if (bus.Flush && (flush_cnt_q != 16'hFFFF)) flush_cnt_q <= flush_cnt_q + 16'd1;
    end
  end

  assign StallCount = stall_cnt_q;
  assign FlushCount = flush_cnt_q;
`endif

endmodule
